mbinit_repair_handshake_seq: RTL and testbench
==============================================

Name: mbinit_repair_handshake_seq

Overview:
Parametrised successor of the single-purpose MBINIT REPAIRVAL/REPAIRCLK sequencers. It runs the sideband handshake init_req/resp -> pattern -> result_req/resp -> done_req/resp for one MBINIT repair step, with a configurable message code base and a multi-bit masked result check. It also adds strict response matching and a handshake timeout. It sits between the MBINIT top-level step chain and the sideband TX/RX wrappers; one instance is used per repair step.

Parameters:
MSG_W, 4, sideband message code width
MSG_BASE, 1, code of init_req; init_resp=+1, result_req=+2, result_resp=+3, done_req=+4, done_resp=+5
RESULT_W, 4, width of the partner-reported result vector (per-lane/per-signal pass bits)
TO_W, 20, timeout counter width
TIMEOUT_CYCLES, 800000, cycles allowed in any non-terminal state before error; must be < 2**TO_W
MAX_RETRY, 2, pattern retries on failed result; used only with REPAIR_RETRY_EN

Ports:
CLK  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_enable  in  1  level; previous step end; low aborts to IDLE
i_busy_sideband  in  1  sideband TX busy
i_falling_edge_busy  in  1  one-cycle pulse; TX accepted a message
i_msg_valid  in  1  RX message strobe
i_rx_sb_message  in  MSG_W  RX message code
i_rx_result  in  RESULT_W  result payload, sampled with result_resp
i_result_mask  in  RESULT_W  bits that must be 1 for pass; static during a step
i_pattern_done  in  1  pattern generator finished
o_pattern_en  out  1  pattern generator enable
o_tx_valid  out  1  TX message valid (level)
o_tx_sb_message  out  MSG_W  TX message code
o_result  out  RESULT_W  latched partner result
o_step_end  out  1  step complete (level)
o_train_error_req  out  1  training error (level)
o_timeout  out  1  error cause was a timeout

Behaviour:
- All outputs are registered and decoded from the next state. Reset value of every output is 0; the FSM resets to IDLE, the counter to 0 and the expected-code register to 0.
- States: IDLE, CHK_BUSY_INIT, SEND_INIT, CHK_BUSY_RES, SEND_RES, CHK_BUSY_DONE, SEND_DONE, WAIT_RESP, PATTERN, CHECK, DONE, ERROR.
- Entry path: IDLE -> CHK_BUSY_INIT when i_enable=1.
- CHK_BUSY_x -> SEND_x when i_busy_sideband=0.
- SEND_x: o_tx_valid=1 and o_tx_sb_message=request code for every cycle in the state. SEND_x -> WAIT_RESP on i_falling_edge_busy. The expected response (request+1) is loaded into the expected-code register on that transition.
- WAIT_RESP advances only when i_msg_valid=1 and the code equals the expected code. Any other code is ignored.
  - init_resp -> PATTERN.
  - result_resp -> CHECK, and latches i_rx_result into o_result.
  - done_resp -> DONE.
- PATTERN: o_pattern_en=1. Exits to CHK_BUSY_RES on i_pattern_done.
- CHECK lasts one cycle. Pass is (o_result & i_result_mask) == i_result_mask.
  - Pass -> CHK_BUSY_DONE.
  - Fail -> ERROR with o_train_error_req=1 when REPAIR_RETRY_EN is off.
- DONE: o_step_end=1, held until i_enable falls.
- ERROR: o_train_error_req=1, held until i_enable falls.
- i_enable=0 in any state: IDLE next cycle, all outputs 0 next cycle. This has priority over all other events.
- Timeout:
  - The counter clears on leaving IDLE and on every state change.
  - It increments each cycle in a non-terminal, non-IDLE state.
  - Reaching TIMEOUT_CYCLES-1 sends the FSM to ERROR with o_timeout=1.
  - If a matching response and the timeout occur in the same cycle, the response wins.
- o_result holds its value through DONE/ERROR and clears on return to IDLE.

Optional Feature:
REPAIR_RETRY_EN:
- Defined: a failed CHECK with retry count < MAX_RETRY increments the retry count and goes to PATTERN, which re-runs the pattern and then result_req. Once the retry count equals MAX_RETRY, a fail goes to ERROR. The retry count clears in IDLE.
- Undefined: no retry logic; a fail goes straight to ERROR.

Decomposition:
- Package mbinit_pkg holds: message offsets (INIT_REQ_OFS=0 .. DONE_RESP_OFS=5), the state enum/localparams and the default timeout constant.
- One sub-module, mbinit_timeout_cnt: a clear/enable saturating counter with a terminal-count pulse, parametrised by TO_W and TIMEOUT_CYCLES.

Test Plan:
1. Nominal run:
   - Stimulus: i_enable=1, busy=0, MSG_BASE=1; respond 2, then pattern_done, then 4 with result=4'hF and mask=4'hF, then 6.
   - Required: TX codes 1, 3, 5 each valid until the busy falling edge; o_step_end=1; o_result=F.
2. Mismatched response:
   - Stimulus: in WAIT_RESP after init_req, inject code 6 with msg_valid, then code 2.
   - Required: code 6 ignored; PATTERN entered only after code 2.
3. Result fail:
   - Stimulus: result=4'b1011, mask=4'b1111.
   - Required without macro: o_train_error_req=1 one cycle after CHECK.
   - Required with macro and MAX_RETRY=2: two extra pattern runs, then error.
4. Timeout:
   - Stimulus: TIMEOUT_CYCLES=16; no response after init_req.
   - Required: ERROR after 16 cycles in WAIT_RESP; o_timeout=1 and o_train_error_req=1.
5. Abort:
   - Stimulus: drop i_enable mid-PATTERN.
   - Required: all outputs 0 next cycle; re-raising i_enable restarts with code 1.
6. Reset:
   - Stimulus: assert rst_n=0 asynchronously during SEND_RES.
   - Required: outputs 0 immediately; FSM in IDLE.

Source files
------------

// File: rtl/mbinit_pkg.sv
// Shared definitions for the MBINIT repair handshake sequencer: message code
// offsets from the configurable base, FSM state encoding and default timeout.
package mbinit_pkg;

    localparam int INIT_REQ_OFS    = 0;
    localparam int INIT_RESP_OFS   = 1;
    localparam int RESULT_REQ_OFS  = 2;
    localparam int RESULT_RESP_OFS = 3;
    localparam int DONE_REQ_OFS    = 4;
    localparam int DONE_RESP_OFS   = 5;

    localparam int DEFAULT_TIMEOUT_CYCLES = 800000;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHK_BUSY_INIT,
        ST_SEND_INIT,
        ST_CHK_BUSY_RES,
        ST_SEND_RES,
        ST_CHK_BUSY_DONE,
        ST_SEND_DONE,
        ST_WAIT_RESP,
        ST_PATTERN,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/mbinit_timeout_cnt.sv
// Clear/enable saturating cycle counter; tc_o pulses combinationally while
// enabled and the count sits at TIMEOUT_CYCLES-1.
module mbinit_timeout_cnt #(
    parameter int TO_W           = 20,
    parameter int TIMEOUT_CYCLES = 800000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/mbinit_repair_handshake_seq.sv
// One MBINIT repair step: init/result/done sideband handshake with masked
// result check and timeout. Optional pattern retry via `REPAIR_RETRY_EN.
module mbinit_repair_handshake_seq
    import mbinit_pkg::*;
#(
    parameter int MSG_W          = 4,
    parameter int MSG_BASE       = 1,
    parameter int RESULT_W       = 4,
    parameter int TO_W           = 20,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int MAX_RETRY      = 2
) (
    input  logic                CLK,
    input  logic                rst_n,
    input  logic                i_enable,
    input  logic                i_busy_sideband,
    input  logic                i_falling_edge_busy,
    input  logic                i_msg_valid,
    input  logic [MSG_W-1:0]    i_rx_sb_message,
    input  logic [RESULT_W-1:0] i_rx_result,
    input  logic [RESULT_W-1:0] i_result_mask,
    input  logic                i_pattern_done,
    output logic                o_pattern_en,
    output logic                o_tx_valid,
    output logic [MSG_W-1:0]    o_tx_sb_message,
    output logic [RESULT_W-1:0] o_result,
    output logic                o_step_end,
    output logic                o_train_error_req,
    output logic                o_timeout
);

    localparam logic [MSG_W-1:0] INIT_REQ    = MSG_W'(MSG_BASE + INIT_REQ_OFS);
    localparam logic [MSG_W-1:0] INIT_RESP   = MSG_W'(MSG_BASE + INIT_RESP_OFS);
    localparam logic [MSG_W-1:0] RESULT_REQ  = MSG_W'(MSG_BASE + RESULT_REQ_OFS);
    localparam logic [MSG_W-1:0] RESULT_RESP = MSG_W'(MSG_BASE + RESULT_RESP_OFS);
    localparam logic [MSG_W-1:0] DONE_REQ    = MSG_W'(MSG_BASE + DONE_REQ_OFS);
    localparam logic [MSG_W-1:0] DONE_RESP   = MSG_W'(MSG_BASE + DONE_RESP_OFS);

    state_t              state_q, state_d;
    logic [MSG_W-1:0]    exp_q, exp_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic                timeout_q, timeout_d;
    logic                pattern_en_q, tx_valid_q, step_end_q, err_q;
    logic [MSG_W-1:0]    tx_msg_q, tx_msg_d;
    logic                cnt_clear, cnt_enable, tc;
    logic                pass;

`ifdef REPAIR_RETRY_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RW-1:0] retry_q, retry_d;
`endif

    assign pass = (result_q & i_result_mask) == i_result_mask;

    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        result_d  = result_q;
`ifdef REPAIR_RETRY_EN
        retry_d   = (state_q == ST_IDLE) ? '0 : retry_q;
`endif
        case (state_q)
            ST_IDLE:          if (i_enable) state_d = ST_CHK_BUSY_INIT;
            ST_CHK_BUSY_INIT: if (!i_busy_sideband) state_d = ST_SEND_INIT;
            ST_CHK_BUSY_RES:  if (!i_busy_sideband) state_d = ST_SEND_RES;
            ST_CHK_BUSY_DONE: if (!i_busy_sideband) state_d = ST_SEND_DONE;
            ST_SEND_INIT: if (i_falling_edge_busy) begin
                state_d = ST_WAIT_RESP;
                exp_d   = INIT_RESP;
            end
            ST_SEND_RES: if (i_falling_edge_busy) begin
                state_d = ST_WAIT_RESP;
                exp_d   = RESULT_RESP;
            end
            ST_SEND_DONE: if (i_falling_edge_busy) begin
                state_d = ST_WAIT_RESP;
                exp_d   = DONE_RESP;
            end
            // Only the exact expected response moves us on; stray codes are dropped.
            ST_WAIT_RESP: if (i_msg_valid && (i_rx_sb_message == exp_q)) begin
                if (exp_q == INIT_RESP) begin
                    state_d = ST_PATTERN;
                end else if (exp_q == RESULT_RESP) begin
                    state_d  = ST_CHECK;
                    result_d = i_rx_result;
                end else if (exp_q == DONE_RESP) begin
                    state_d = ST_DONE;
                end
            end
            ST_PATTERN: if (i_pattern_done) state_d = ST_CHK_BUSY_RES;
            ST_CHECK: begin
                if (pass) begin
                    state_d = ST_CHK_BUSY_DONE;
                end else begin
`ifdef REPAIR_RETRY_EN
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_PATTERN;
                    end else begin
                        state_d = ST_ERROR;
                    end
`else
                    state_d = ST_ERROR;
`endif
                end
            end
            default: state_d = state_q;
        endcase

        // A response arriving on the terminal-count cycle has already moved state_d.
        if (tc && (state_d == state_q)) begin
            state_d = ST_ERROR;
        end
        timeout_d = (state_d == ST_ERROR) &&
                    (timeout_q || (tc && (state_q != ST_ERROR)));

        if (!i_enable) begin
            state_d   = ST_IDLE;
            timeout_d = 1'b0;
        end
        if (state_d == ST_IDLE) begin
            result_d = '0;
        end
    end

    always_comb begin
        tx_msg_d = '0;
        case (state_d)
            ST_SEND_INIT: tx_msg_d = INIT_REQ;
            ST_SEND_RES:  tx_msg_d = RESULT_REQ;
            ST_SEND_DONE: tx_msg_d = DONE_REQ;
            default:      tx_msg_d = '0;
        endcase
    end

    assign cnt_clear  = (state_q == ST_IDLE) || (state_d != state_q);
    assign cnt_enable = (state_q != ST_IDLE) && (state_q != ST_DONE) &&
                        (state_q != ST_ERROR);

    mbinit_timeout_cnt #(
        .TO_W           (TO_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk      (CLK),
        .rst_n    (rst_n),
        .clear_i  (cnt_clear),
        .enable_i (cnt_enable),
        .tc_o     (tc)
    );

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            exp_q        <= '0;
            result_q     <= '0;
            timeout_q    <= 1'b0;
            pattern_en_q <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_msg_q     <= '0;
            step_end_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            result_q     <= result_d;
            timeout_q    <= timeout_d;
            pattern_en_q <= (state_d == ST_PATTERN);
            tx_valid_q   <= (state_d == ST_SEND_INIT) || (state_d == ST_SEND_RES) ||
                            (state_d == ST_SEND_DONE);
            tx_msg_q     <= tx_msg_d;
            step_end_q   <= (state_d == ST_DONE);
            err_q        <= (state_d == ST_ERROR);
        end
    end

`ifdef REPAIR_RETRY_EN
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            retry_q <= '0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

    assign o_pattern_en      = pattern_en_q;
    assign o_tx_valid        = tx_valid_q;
    assign o_tx_sb_message   = tx_msg_q;
    assign o_result          = result_q;
    assign o_step_end        = step_end_q;
    assign o_train_error_req = err_q;
    assign o_timeout         = timeout_q;

endmodule

// File: tb/tb_mbinit_repair_handshake_seq.sv
// Directed self-checking bench for mbinit_repair_handshake_seq (TIMEOUT_CYCLES=16);
// also covers the REPAIR_RETRY_EN build when that macro is defined.
module tb_mbinit_repair_handshake_seq;

    logic       clk;
    logic       rst_n;
    logic       i_enable;
    logic       i_busy_sideband;
    logic       i_falling_edge_busy;
    logic       i_msg_valid;
    logic [3:0] i_rx_sb_message;
    logic [3:0] i_rx_result;
    logic [3:0] i_result_mask;
    logic       i_pattern_done;
    logic       o_pattern_en;
    logic       o_tx_valid;
    logic [3:0] o_tx_sb_message;
    logic [3:0] o_result;
    logic       o_step_end;
    logic       o_train_error_req;
    logic       o_timeout;

    int checks   = 0;
    int failures = 0;

    mbinit_repair_handshake_seq #(
        .MSG_W          (4),
        .MSG_BASE       (1),
        .RESULT_W       (4),
        .TO_W           (20),
        .TIMEOUT_CYCLES (16),
        .MAX_RETRY      (2)
    ) dut (
        .CLK                 (clk),
        .rst_n               (rst_n),
        .i_enable            (i_enable),
        .i_busy_sideband     (i_busy_sideband),
        .i_falling_edge_busy (i_falling_edge_busy),
        .i_msg_valid         (i_msg_valid),
        .i_rx_sb_message     (i_rx_sb_message),
        .i_rx_result         (i_rx_result),
        .i_result_mask       (i_result_mask),
        .i_pattern_done      (i_pattern_done),
        .o_pattern_en        (o_pattern_en),
        .o_tx_valid          (o_tx_valid),
        .o_tx_sb_message     (o_tx_sb_message),
        .o_result            (o_result),
        .o_step_end          (o_step_end),
        .o_train_error_req   (o_train_error_req),
        .o_timeout           (o_timeout)
    );

    // 10 ns clock; all stimulus and sampling happen 1 ns after the rising edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic [3:0] res, input logic [3:0] mask);
        i_enable      = en;
        i_rx_result   = res;
        i_result_mask = mask;
    endtask

    task automatic waitTx(input string tag, input logic [3:0] code);
        int n = 0;
        while (!o_tx_valid && n < 20) begin
            step();
            n++;
        end
        checkOutput({tag, "_valid"}, {31'd0, o_tx_valid}, 32'd1);
        checkOutput({tag, "_code"}, {28'd0, o_tx_sb_message}, {28'd0, code});
    endtask

    task automatic ackTx();
        i_falling_edge_busy = 1'b1;
        step();
        i_falling_edge_busy = 1'b0;
    endtask

    task automatic respond(input logic [3:0] code);
        i_msg_valid     = 1'b1;
        i_rx_sb_message = code;
        step();
        i_msg_valid     = 1'b0;
        i_rx_sb_message = 4'd0;
    endtask

    task automatic pulsePatternDone();
        i_pattern_done = 1'b1;
        step();
        i_pattern_done = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput(tag, {25'd0, o_pattern_en, o_tx_valid, o_step_end, o_train_error_req,
                          o_timeout, (o_tx_sb_message != 4'd0), (o_result != 4'd0)}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        i_busy_sideband = 1'b0;
        i_falling_edge_busy = 1'b0;
        i_msg_valid = 1'b0;
        i_rx_sb_message = 4'd0;
        i_pattern_done = 1'b0;
        applyStimulus(1'b0, 4'h0, 4'hF);
        step();
        step();
        checkAllZero("reset_outputs");
        rst_n = 1'b1;
        step();

        // Nominal handshake, codes 1/3/5 and responses 2/4/6
        applyStimulus(1'b1, 4'hF, 4'hF);
        waitTx("nom_init", 4'd1);
        step();
        checkOutput("nom_init_held", {31'd0, o_tx_valid}, 32'd1);
        ackTx();
        checkOutput("nom_init_drop", {31'd0, o_tx_valid}, 32'd0);
        respond(4'd2);
        checkOutput("nom_pattern_en", {31'd0, o_pattern_en}, 32'd1);
        pulsePatternDone();
        checkOutput("nom_pattern_off", {31'd0, o_pattern_en}, 32'd0);
        waitTx("nom_res", 4'd3);
        ackTx();
        respond(4'd4);
        checkOutput("nom_result", {28'd0, o_result}, 32'hF);
        waitTx("nom_done", 4'd5);
        ackTx();
        respond(4'd6);
        checkOutput("nom_step_end", {31'd0, o_step_end}, 32'd1);
        step();
        checkOutput("nom_step_end_held", {31'd0, o_step_end}, 32'd1);
        checkOutput("nom_result_held", {28'd0, o_result}, 32'hF);
        checkOutput("nom_no_error", {31'd0, o_train_error_req}, 32'd0);
        i_enable = 1'b0;
        step();
        checkAllZero("nom_disable_zero");

        // Stray codes in WAIT_RESP must be ignored
        i_enable = 1'b1;
        waitTx("mm_init", 4'd1);
        ackTx();
        respond(4'd6);
        checkOutput("mm_code6_ignored", {31'd0, o_pattern_en}, 32'd0);
        respond(4'd4);
        checkOutput("mm_code4_ignored", {31'd0, o_pattern_en}, 32'd0);
        respond(4'd2);
        checkOutput("mm_code2_pattern", {31'd0, o_pattern_en}, 32'd1);

        // Abort mid-PATTERN, then restart
        step();
        i_enable = 1'b0;
        step();
        checkAllZero("abort_zero");
        i_enable = 1'b1;
        waitTx("abort_restart", 4'd1);

        // Result fail: 1011 against mask 1111
        applyStimulus(1'b1, 4'b1011, 4'b1111);
        ackTx();
        respond(4'd2);
        pulsePatternDone();
        waitTx("fail_res", 4'd3);
        ackTx();
        respond(4'd4);
        checkOutput("fail_result", {28'd0, o_result}, 32'hB);
        checkOutput("fail_no_err_yet", {31'd0, o_train_error_req}, 32'd0);
`ifdef REPAIR_RETRY_EN
        for (int r = 0; r < 2; r++) begin
            step();
            checkOutput("retry_pattern_en", {31'd0, o_pattern_en}, 32'd1);
            pulsePatternDone();
            waitTx("retry_res", 4'd3);
            ackTx();
            respond(4'd4);
        end
`endif
        step();
        checkOutput("fail_error", {31'd0, o_train_error_req}, 32'd1);
        checkOutput("fail_not_timeout", {31'd0, o_timeout}, 32'd0);
        checkOutput("fail_result_held", {28'd0, o_result}, 32'hB);
        i_enable = 1'b0;
        step();
        checkAllZero("fail_disable_zero");

        // Timeout: 16 cycles in WAIT_RESP with no response
        applyStimulus(1'b1, 4'hF, 4'hF);
        waitTx("to_init", 4'd1);
        ackTx();
        for (int c = 0; c < 15; c++) step();
        checkOutput("to_not_yet", {31'd0, o_train_error_req}, 32'd0);
        step();
        checkOutput("to_error", {31'd0, o_train_error_req}, 32'd1);
        checkOutput("to_flag", {31'd0, o_timeout}, 32'd1);
        i_enable = 1'b0;
        step();
        checkAllZero("to_disable_zero");

        // Matching response on the terminal-count cycle wins over the timeout
        i_enable = 1'b1;
        waitTx("race_init", 4'd1);
        ackTx();
        for (int c = 0; c < 15; c++) step();
        respond(4'd2);
        checkOutput("race_pattern", {31'd0, o_pattern_en}, 32'd1);
        checkOutput("race_no_error", {31'd0, o_train_error_req}, 32'd0);
        checkOutput("race_no_timeout", {31'd0, o_timeout}, 32'd0);

        // Asynchronous reset during SEND_RES
        pulsePatternDone();
        waitTx("rst_res", 4'd3);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("rst_async_zero");
        step();
        rst_n = 1'b1;
        checkAllZero("rst_held_zero");
        waitTx("rst_restart", 4'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
